// File: rtl/sb_cfg_shadow.sv
// Switch block whose routing is scanned in over ccff and applied atomically on commit.
// Define SB_CFG_PARITY_EN to add an even-parity bit at the head of the chain.
module sb_cfg_shadow #(
    parameter int CHAN_W = 9,
    parameter int SEL_W  = 2,
    localparam int L     = 2 * CHAN_W * SEL_W,
`ifdef SB_CFG_PARITY_EN
    localparam int CL    = L + 1,
`else
    localparam int CL    = L,
`endif
    localparam int CNT_W = $clog2(CL + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] bottom_pin_in,
    input  logic [CHAN_W-1:0] left_pin_in,
    input  logic              ccff_head,
    input  logic              ccff_shift_en,
    input  logic              ccff_commit,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic              ccff_tail,
    output logic [CNT_W-1:0]  cfg_count,
    output logic              cfg_valid,
    output logic              cfg_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CL-1:0]     sreg;
    logic [L-1:0]      shd;
    logic [CHAN_W-1:0] xb;
    logic [CHAN_W-1:0] xl;
    logic [CHAN_W-1:0] xb_q;
    logic [CHAN_W-1:0] xl_q;
    logic              par_ok;
    logic              cnt_full;
    logic              commit_req;
    logic              commit_ok;
    logic              err_nxt;

    // Cross tracks: bottom i takes left (i+1), left i takes bottom (i-1).
    for (genvar i = 0; i < CHAN_W; i++) begin : g_cross
        assign xb[i] = chanx_left_in[(i + 1) % CHAN_W];
        assign xl[i] = chany_bottom_in[(i + CHAN_W - 1) % CHAN_W];
    end

`ifdef SB_CFG_PARITY_EN
    assign par_ok = ~^sreg;
`else
    assign par_ok = 1'b1;
`endif

    assign ccff_tail  = sreg[CL-1];
    assign cnt_full   = (cfg_count == CNT_W'(CL));
    assign commit_req = (state == ST_IDLE) && ccff_commit && !ccff_shift_en;
    assign commit_ok  = commit_req && cnt_full && par_ok;
    assign err_nxt    = (ccff_commit && ccff_shift_en) || (commit_req && !commit_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ccff_shift_en)
                    state_nxt = ST_SHIFT;
                else if (ccff_commit)
                    state_nxt = ST_COMMIT;
            end
            ST_SHIFT: begin
                if (!ccff_shift_en)
                    state_nxt = ST_IDLE;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state   <= ST_IDLE;
            cfg_err <= 1'b0;
            xb_q    <= '0;
            xl_q    <= '0;
        end else begin
            state   <= state_nxt;
            cfg_err <= err_nxt;
            xb_q    <= xb;
            xl_q    <= xl;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            sreg <= '0;
        end else if (ccff_shift_en) begin
            sreg <= {sreg[CL-2:0], ccff_head};
        end
    end

    // A commit never coincides with a shift, so the two branches are exclusive.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            shd       <= '0;
            cfg_valid <= 1'b0;
            cfg_count <= '0;
        end else if (commit_ok) begin
            shd       <= sreg[L-1:0];
            cfg_valid <= 1'b1;
            cfg_count <= '0;
        end else if (ccff_shift_en && !cnt_full) begin
            cfg_count <= cfg_count + CNT_W'(1);
        end
    end

    always_comb begin
        chany_bottom_out = '0;
        chanx_left_out   = '0;
        for (int i = 0; i < CHAN_W; i++) begin
            case (shd[2*i +: 2])
                2'd1:    chany_bottom_out[i] = bottom_pin_in[i];
                2'd2:    chany_bottom_out[i] = xb[i];
                2'd3:    chany_bottom_out[i] = xb_q[i];
                default: chany_bottom_out[i] = 1'b0;
            endcase
            case (shd[2*(CHAN_W+i) +: 2])
                2'd1:    chanx_left_out[i] = left_pin_in[i];
                2'd2:    chanx_left_out[i] = xl[i];
                2'd3:    chanx_left_out[i] = xl_q[i];
                default: chanx_left_out[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_cfg_shadow.sv
// Randomized directed bench for sb_cfg_shadow against a bit-queue reference model.
// Honors SB_CFG_PARITY_EN the same way the design does.
module tb_sb_cfg_shadow;

    localparam int W = 9;
    localparam int L = 2 * W * 2;
`ifdef SB_CFG_PARITY_EN
    localparam int CL = L + 1;
`else
    localparam int CL = L;
`endif
    localparam int CNT_W = $clog2(CL + 1);

    logic             prog_clk = 1'b0;
    logic             prog_rst_n;
    logic [W-1:0]     chany_bottom_in;
    logic [W-1:0]     chanx_left_in;
    logic [W-1:0]     bottom_pin_in;
    logic [W-1:0]     left_pin_in;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_commit;
    logic [W-1:0]     chany_bottom_out;
    logic [W-1:0]     chanx_left_out;
    logic             ccff_tail;
    logic [CNT_W-1:0] cfg_count;
    logic             cfg_valid;
    logic             cfg_err;

    sb_cfg_shadow #(.CHAN_W(W), .SEL_W(2)) dut (
        .prog_clk         (prog_clk),
        .prog_rst_n       (prog_rst_n),
        .chany_bottom_in  (chany_bottom_in),
        .chanx_left_in    (chanx_left_in),
        .bottom_pin_in    (bottom_pin_in),
        .left_pin_in      (left_pin_in),
        .ccff_head        (ccff_head),
        .ccff_shift_en    (ccff_shift_en),
        .ccff_commit      (ccff_commit),
        .chany_bottom_out (chany_bottom_out),
        .chanx_left_out   (chanx_left_out),
        .ccff_tail        (ccff_tail),
        .cfg_count        (cfg_count),
        .cfg_valid        (cfg_valid),
        .cfg_err          (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: every bit ever shifted, oldest first.
    bit           q[$];
    int           n_sh;
    logic [L-1:0] shd_m;
    bit           valid_m;
    bit           err_m;
    bit           prev_shift;
    bit           prev_cm;
    logic [W-1:0] pxl;
    logic [W-1:0] pyb;

    task automatic model_reset();
        q.delete();
        n_sh       = 0;
        shd_m      = '0;
        valid_m    = 1'b0;
        err_m      = 1'b0;
        prev_shift = 1'b0;
        prev_cm    = 1'b0;
        pxl        = '0;
        pyb        = '0;
    endtask

    function automatic logic [CL-1:0] sreg_now();
        logic [CL-1:0] r;
        int idx;
        r = '0;
        for (int j = 0; j < CL; j++) begin
            idx = q.size() - 1 - j;
            if (idx >= 0) r[j] = q[idx];
        end
        return r;
    endfunction

    function automatic bit parity_ok(input logic [CL-1:0] s);
`ifdef SB_CFG_PARITY_EN
        return ($countones(s) % 2) == 0;
`else
        return (s === s) || 1'b1;
`endif
    endfunction

    function automatic logic [W-1:0] exp_bot();
        logic [W-1:0] r;
        int c;
        r = '0;
        for (int i = 0; i < W; i++) begin
            c = (i + 1) % W;
            case (int'(shd_m[2*i +: 2]))
                1: r[i] = bottom_pin_in[i];
                2: r[i] = chanx_left_in[c];
                3: r[i] = pxl[c];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_left();
        logic [W-1:0] r;
        int c;
        r = '0;
        for (int i = 0; i < W; i++) begin
            c = (i + W - 1) % W;
            case (int'(shd_m[2*(W+i) +: 2]))
                1: r[i] = left_pin_in[i];
                2: r[i] = chany_bottom_in[c];
                3: r[i] = pyb[c];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CL-1:0] s;
        int cnt;
        s   = sreg_now();
        cnt = (n_sh >= CL) ? CL : n_sh;
        chk({tag, ".bot"},   64'(chany_bottom_out), 64'(exp_bot()));
        chk({tag, ".left"},  64'(chanx_left_out),   64'(exp_left()));
        chk({tag, ".tail"},  64'(ccff_tail),        64'(s[CL-1]));
        chk({tag, ".count"}, 64'(cfg_count),        64'(cnt));
        chk({tag, ".valid"}, 64'(cfg_valid),        64'(valid_m));
        chk({tag, ".err"},   64'(cfg_err),          64'(err_m));
    endtask

    task automatic tick(input string tag);
        logic [CL-1:0] s;
        bit idle, acc, ok;
        s    = sreg_now();
        idle = !prev_shift && !prev_cm;
        acc  = idle && ccff_commit && !ccff_shift_en;
        ok   = (n_sh >= CL) && parity_ok(s);
        err_m = (ccff_commit && ccff_shift_en) || (acc && !ok);
        if (acc && ok) begin
            shd_m   = s[L-1:0];
            valid_m = 1'b1;
            n_sh    = 0;
        end
        if (ccff_shift_en) begin
            q.push_back(ccff_head);
            n_sh++;
        end
        prev_cm    = acc;
        prev_shift = ccff_shift_en;
        pxl        = chanx_left_in;
        pyb        = chany_bottom_in;
        @(posedge prog_clk);
        #1;
        check_all(tag);
    endtask

    task automatic rnd_inputs();
        chany_bottom_in = W'($urandom);
        chanx_left_in   = W'($urandom);
        bottom_pin_in   = W'($urandom);
        left_pin_in     = W'($urandom);
    endtask

    task automatic shift_bit(input logic b);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        tick("shift");
    endtask

    task automatic shift_cfg(input logic [L-1:0] w);
`ifdef SB_CFG_PARITY_EN
        shift_bit(^w);
`endif
        for (int j = L - 1; j >= 0; j--) begin
            shift_bit(w[j]);
            if (j % 4 == 0) rnd_inputs();
        end
        ccff_shift_en = 1'b0;
        tick("idle");
    endtask

    task automatic do_commit();
        ccff_commit = 1'b1;
        tick("commit");
        ccff_commit = 1'b0;
    endtask

    function automatic logic [L-1:0] rnd_word();
        return L'({$urandom, $urandom});
    endfunction

    initial begin
        logic [W-1:0] prev_x;
        logic [W-1:0] rot;

        prog_rst_n      = 1'b0;
        chany_bottom_in = '0;
        chanx_left_in   = '0;
        bottom_pin_in   = '0;
        left_pin_in     = '0;
        ccff_head       = 1'b0;
        ccff_shift_en   = 1'b0;
        ccff_commit     = 1'b0;
        model_reset();

        repeat (2) @(posedge prog_clk);
        #1;
        check_all("reset");
        chk("reset.bot0", 64'(chany_bottom_out), 64'd0);
        chk("reset.tail0", 64'(ccff_tail), 64'd0);
        prog_rst_n = 1'b1;
        rnd_inputs();
        tick("post_reset");

        // All muxes select their grid pin.
        shift_cfg({(2*W){2'b01}});
        do_commit();
        chk("c01.valid", 64'(cfg_valid), 64'd1);
        chk("c01.count", 64'(cfg_count), 64'd0);
        bottom_pin_in = 9'h1A5;
        left_pin_in   = W'($urandom);
        #1;
        chk("c01.pin1a5", 64'(chany_bottom_out), 64'h1A5);
        chk("c01.leftpin", 64'(chanx_left_out), 64'(left_pin_in));
        tick("c01.hold");

        // Short chain: rejected commit.
        for (int j = 0; j < CL - 1; j++) shift_bit(1'($urandom));
        ccff_shift_en = 1'b0;
        tick("short.idle");
        do_commit();
        chk("short.err", 64'(cfg_err), 64'd1);
        chk("short.pin", 64'(chany_bottom_out), 64'h1A5);
        tick("short.after");
        chk("short.err_gone", 64'(cfg_err), 64'd0);

        // All muxes take the combinational cross track.
        shift_cfg({(2*W){2'b10}});
        do_commit();
        for (int j = 0; j < 20; j++) begin
            shift_bit(1'($urandom));
            rnd_inputs();
            #1;
            check_all("c10.live");
        end
        ccff_shift_en = 1'b0;
        tick("c10.idle");
        chanx_left_in[1] = 1'b1;
        #1;
        chk("c10.x1hi", 64'(chany_bottom_out[0]), 64'd1);
        chanx_left_in[1] = 1'b0;
        #1;
        chk("c10.x1lo", 64'(chany_bottom_out[0]), 64'd0);
        tick("c10.end");

        // All muxes take the registered cross track.
        shift_cfg({(2*W){2'b11}});
        do_commit();
        for (int j = 0; j < 12; j++) begin
            prev_x        = W'($urandom);
            chanx_left_in = prev_x;
            tick("c11.step");
            chanx_left_in = W'($urandom);
            #1;
            rot = (prev_x >> 1) | (prev_x << (W - 1));
            chk("c11.lag", 64'(chany_bottom_out), 64'(rot));
        end

        // Commit together with shift: shift wins, commit flagged.
        ccff_head     = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_commit   = 1'b1;
        tick("cs");
        chk("cs.err", 64'(cfg_err), 64'd1);
        ccff_shift_en = 1'b0;
        ccff_commit   = 1'b0;
        tick("cs.idle");

        // Count saturation; data keeps moving.
        for (int j = 0; j < CL + 3; j++) shift_bit(1'($urandom));
        chk("sat.count", 64'(cfg_count), 64'(CL));
        ccff_shift_en = 1'b0;
        tick("sat.idle");

`ifdef SB_CFG_PARITY_EN
        begin
            logic [L-1:0] w;
            w = rnd_word();
            shift_bit(~^w);
            for (int j = L - 1; j >= 0; j--) shift_bit(w[j]);
            ccff_shift_en = 1'b0;
            tick("par.idle");
            do_commit();
            chk("par.err", 64'(cfg_err), 64'd1);
            tick("par.after");
        end
`endif

        // Random mixed configurations.
        for (int k = 0; k < 3; k++) begin
            shift_cfg(rnd_word());
            do_commit();
            for (int j = 0; j < 8; j++) begin
                rnd_inputs();
                #1;
                check_all("mix.comb");
                tick("mix.step");
            end
        end

        // Reset in the middle of a shift.
        for (int j = 0; j < 20; j++) shift_bit(1'($urandom));
        prog_rst_n = 1'b0;
        #2;
        model_reset();
        check_all("rstmid");
        chk("rstmid.count", 64'(cfg_count), 64'd0);
        chk("rstmid.bot", 64'(chany_bottom_out), 64'd0);
        ccff_shift_en = 1'b0;
        @(posedge prog_clk);
        #1;
        prog_rst_n = 1'b1;
        #1;
        check_all("rstmid.rel");
        tick("rstmid.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_cfg_shadow.md
# sb_cfg_shadow

Parametrised switch block for the FPGA routing fabric. Bottom and left channels are `CHAN_W` tracks wide, and every output mux has four selectable modes, including a registered one. Configuration arrives over the `ccff` scan chain and is captured into a shadow register, then applied atomically on a commit. This lets the routing be reprogrammed while live without glitching outputs. It is the successor to the fixed 9-track, 2-input switch blocks used in corner tiles.

## Interface
Parameters:
- `CHAN_W`, default 9: tracks per side; there are 2*`CHAN_W` output muxes.
- `SEL_W`, fixed 2: config bits per mux. Chain length is L = 2*`CHAN_W`*`SEL_W` (36 at default).

Ports:
- `prog_clk`  in  1  single clock for the chain, FSM and registered path
- `prog_rst_n`  in  1  asynchronous, active-low reset
- `chany_bottom_in`  in  `CHAN_W`  bottom channel tracks
- `chanx_left_in`  in  `CHAN_W`  left channel tracks
- `bottom_pin_in`  in  `CHAN_W`  grid pins feeding the bottom muxes
- `left_pin_in`  in  `CHAN_W`  grid pins feeding the left muxes
- `ccff_head`  in  1  serial config input
- `ccff_shift_en`  in  1  shift one bit per cycle while high
- `ccff_commit`  in  1  request to load the shift register into the shadow register
- `chany_bottom_out`  out  `CHAN_W`  bottom outputs
- `chanx_left_out`  out  `CHAN_W`  left outputs
- `ccff_tail`  out  1  serial config output, MSB of the shift register
- `cfg_count`  out  clog2(L+1)  number of bits shifted since the last commit or reset, saturating at L
- `cfg_valid`  out  1  high once any commit has succeeded
- `cfg_err`  out  1  one-cycle pulse when a commit is rejected

## Operation
- Shift register `sreg[L-1:0]`: on each cycle with `ccff_shift_en` high, `sreg <= {sreg[L-2:0], ccff_head}`. `ccff_tail = sreg[L-1]`. The first bit shifted in ends at `sreg[L-1]` after L shifts.
- `cfg_count` increments on each shift and saturates at L. Further shifts still move data.
- Shadow register `shd[L-1:0]` drives the muxes. Mux k selects with `shd[2k+1:2k]`.
  - k = 0..`CHAN_W`-1 drive `chany_bottom_out[k]`.
  - k = `CHAN_W`+i drives `chanx_left_out[i]`.
- Select encoding for bottom output i:
  - 0: constant 0
  - 1: `bottom_pin_in[i]`
  - 2: `chanx_left_in[(i+1) mod CHAN_W]`
  - 3: the same cross track, registered
- Select encoding for left output i:
  - 0: constant 0
  - 1: `left_pin_in[i]`
  - 2: `chany_bottom_in[(i-1) mod CHAN_W]`
  - 3: the same cross track, registered
- FSM states:
  - IDLE → SHIFT when `ccff_shift_en` is high.
  - SHIFT → IDLE when `ccff_shift_en` is low.
  - IDLE with `ccff_commit` → COMMIT for one cycle, then → IDLE.
- COMMIT: if `cfg_count` == L (and parity passes when enabled), then `shd <= sreg`, `cfg_valid <= 1`, `cfg_count <= 0`. Otherwise `cfg_err` pulses, and `shd`, `cfg_count` and `cfg_valid` are unchanged.
- Simultaneous `ccff_commit` and `ccff_shift_en`: the shift takes priority, the commit is ignored, and `cfg_err` pulses.
- `sreg` is never cleared by a commit.
- Reset, asynchronous: `sreg`, `shd`, `cfg_count`, `cfg_valid`, `cfg_err`, the registered-path flops and the FSM (to IDLE) all go to 0. All outputs are therefore 0 and `ccff_tail` is 0. Reset mid-shift discards the partial configuration.

## Timing
- Modes 0–2 are combinational from the inputs to the outputs.
- Mode 3 has 1-cycle latency: the cross track is sampled on the `prog_clk` rising edge.
- A shift is visible on `ccff_tail` and `cfg_count` the cycle after the edge it occurs on.
- Commit is accepted on the edge where the request is sampled in IDLE. New routing, `cfg_valid` and `cfg_err` are visible after that edge.
- The registered-path flops clock every cycle regardless of the selected mode. Switching into mode 3 therefore presents an already-current value.

## Configuration
- `SB_CFG_PARITY_EN` defined:
  - Chain length becomes L+1 and `cfg_count` saturates at L+1.
  - The extra bit is the first-shifted bit, held in `sreg[L]`. It must make the total number of 1s in `sreg[L:0]` even.
  - A commit with a mismatch is rejected with a `cfg_err` pulse.
  - `ccff_tail = sreg[L]`.
- Not defined: chain length L, no parity check.

## Test plan
- Reset → all outputs 0, `cfg_valid`=0, `cfg_count`=0, `ccff_tail`=0.
- Shift 36 bits encoding `01` in every mux (`shd` = 0x5_5555_5555), then commit → `cfg_valid`=1, `cfg_count`=0, and both output sides equal their pin inputs. Drive pins 0x1A5 → `chany_bottom_out` = 0x1A5.
- Shift only 35 bits, then commit → `cfg_err` pulse for 1 cycle and outputs unchanged.
- After an all-`10` config is live, shift a new pattern → outputs keep following the cross tracks until commit. Toggle `chanx_left_in[1]` → `chany_bottom_out[0]` follows combinationally.
- All-`11` config, with `chanx_left_in` stepping one value per cycle → `chany_bottom_out` lags by exactly 1 cycle, rotated per the cross-track mapping.
- Assert commit and shift together → the shift happens and `cfg_err` pulses. Assert reset mid-shift at bit 20 → `cfg_count`=0 and outputs 0.
